// File: rtl/pipe_ex_mem_elastic.sv
// EX/MEM pipeline register with valid/ready flow control, optional 2-entry skid buffer and flush.
// Control outputs are gated by out_valid so bubbles and flushed slots never write anything.
module pipe_ex_mem_elastic #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             MEMWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             REGWRITE_IN,
  input  logic [WIDTH-1:0] RESULTOP_IN,
  input  logic [WIDTH-1:0] WRDATA_IN,
  input  logic [AW-1:0]    ARD_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             MEMWRITE_OUT,
  output logic             MEMTOREG_OUT,
  output logic             REGWRITE_OUT,
  output logic [WIDTH-1:0] RESULTOP_OUT,
  output logic [WIDTH-1:0] WRDATA_OUT,
  output logic [AW-1:0]    ARD_OUT,
  output logic [1:0]       occ,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holding valid=1 may not be assumed accepted until that edge.
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic             mw;
    logic             mtr;
    logic             rw;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    ard;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_ent;
  logic   in_fire, out_fire, out_valid_i;
  logic   load_main_in, load_main_skid;

  // Writes to x0 are architecturally discarded, so drop the enable on entry.
  assign in_ent = {MEMWRITE_IN, MEMTOREG_IN, REGWRITE_IN & (ARD_IN != '0),
                   RESULTOP_IN, WRDATA_IN, ARD_IN};

  assign out_valid_i = (state_q != EMPTY);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid_i & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = HALF;
          load_main_in = 1'b1;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          if (SKID != 0) state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = HALF;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
      if (load_main_in)        main_q <= in_ent;
      else if (load_main_skid) main_q <= skid_q;
    end
  end

  if (SKID != 0) begin : g_skid
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (!rst) begin
        skid_q     <= '0;
        in_ready_q <= 1'b1;
      end else if (flush) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != FULL);
        if (state_q == HALF && state_d == FULL) skid_q <= in_ent;
      end
    end
    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign skid_q   = '0;
    assign in_ready = !out_valid_i | out_ready;
  end

  assign out_valid    = out_valid_i;
  assign MEMWRITE_OUT = main_q.mw  & out_valid_i;
  assign MEMTOREG_OUT = main_q.mtr & out_valid_i;
  assign REGWRITE_OUT = main_q.rw  & out_valid_i;
  assign RESULTOP_OUT = main_q.res;
  assign WRDATA_OUT   = main_q.wd;
  assign ARD_OUT      = main_q.ard;
  assign occ          = state_q;
  assign dbg_state    = state_q;

endmodule
